// File: rtl/mips_ctrl_pkg.sv
// Shared opcode, state and control-bundle definitions for the
// multicycle MIPS sequencer.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       bne;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore control decode: state (+opcode, mem_ready) -> control bundle.
// State 11 decodes to JUMP only when MC_JUMP_EN is defined.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
        ctrl.bne           = (opcode == OP_BNE);
        ctrl.instr_done    = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCS_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      S_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state and sticky
// illegal flag. Optional J support under MC_JUMP_EN.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       BNE,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       halted,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   ill_q, ill_d;
  ctrl_t  ctrl, ctrl_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MEM_ADDR;
          (opcode == OP_RTYPE): state_d = S_R_EXEC;
          (opcode == OP_BEQ),
          (opcode == OP_BNE):   state_d = S_BRANCH;
          (opcode == OP_ADDI):  state_d = S_ADDI_EXEC;
`ifdef MC_JUMP_EN
          (opcode == OP_J):     state_d = S_JUMP;
`endif
          default: begin
            ill_d = 1'b1;
            if (HALT_ON_ILLEGAL) state_d = S_HALT;
            else                 state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR:
        if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                 state_d = S_MEM_READ;
      S_MEM_READ:
        if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE:
        if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_dec (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset kills every control immediately, so no partial commit.
  assign ctrl_o = reset ? '0 : ctrl;

  assign PCWrite     = ctrl_o.pc_write;
  assign PCWriteCond = ctrl_o.pc_write_cond;
  assign IorD        = ctrl_o.iord;
  assign MemRead     = ctrl_o.mem_read;
  assign MemWrite    = ctrl_o.mem_write;
  assign IRWrite     = ctrl_o.ir_write;
  assign MemtoReg    = ctrl_o.mem_to_reg;
  assign RegWrite    = ctrl_o.reg_write;
  assign RegDst      = ctrl_o.reg_dst;
  assign ALUSrcA     = ctrl_o.alu_src_a;
  assign ALUSrcB     = ctrl_o.alu_src_b;
  assign ALUOp       = ctrl_o.alu_op;
  assign PCSource    = ctrl_o.pc_source;
  assign BNE         = ctrl_o.bne;
  assign instr_done  = ctrl_o.instr_done;
  assign halted      = ctrl_o.halted;
  assign illegal_op  = ill_q & ~reset;
  assign state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: two DUTs (halt / skip on
// illegal) share stimulus and are checked against a cycle-plan model.
module tb_multicycle_control;

  typedef struct {
    int         st;
    logic       mr;
    logic [5:0] op;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  logic       h_pcw, h_pcc, h_iord, h_mrd, h_mwr, h_irw, h_m2r, h_rw;
  logic       h_rd, h_sa, h_bn, h_dn, h_ill, h_hl;
  logic [1:0] h_sb, h_ao, h_ps;
  logic [3:0] h_st;
  logic       s_pcw, s_pcc, s_iord, s_mrd, s_mwr, s_irw, s_m2r, s_rw;
  logic       s_rd, s_sa, s_bn, s_dn, s_ill, s_hl;
  logic [1:0] s_sb, s_ao, s_ps;
  logic [3:0] s_st;

  multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(h_pcw), .PCWriteCond(h_pcc), .IorD(h_iord),
    .MemRead(h_mrd), .MemWrite(h_mwr), .IRWrite(h_irw),
    .MemtoReg(h_m2r), .RegWrite(h_rw), .RegDst(h_rd),
    .ALUSrcA(h_sa), .ALUSrcB(h_sb), .ALUOp(h_ao),
    .PCSource(h_ps), .BNE(h_bn), .instr_done(h_dn),
    .illegal_op(h_ill), .halted(h_hl), .state(h_st)
  );

  multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut_s (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(s_pcw), .PCWriteCond(s_pcc), .IorD(s_iord),
    .MemRead(s_mrd), .MemWrite(s_mwr), .IRWrite(s_irw),
    .MemtoReg(s_m2r), .RegWrite(s_rw), .RegDst(s_rd),
    .ALUSrcA(s_sa), .ALUSrcB(s_sb), .ALUOp(s_ao),
    .PCSource(s_ps), .BNE(s_bn), .instr_done(s_dn),
    .illegal_op(s_ill), .halted(s_hl), .state(s_st)
  );

  wire [18:0] h_ctl = {h_pcw, h_pcc, h_iord, h_mrd, h_mwr, h_irw, h_m2r,
                       h_rw, h_rd, h_sa, h_sb, h_ao, h_ps, h_bn, h_dn, h_hl};
  wire [18:0] s_ctl = {s_pcw, s_pcc, s_iord, s_mrd, s_mwr, s_irw, s_m2r,
                       s_rw, s_rd, s_sa, s_sb, s_ao, s_ps, s_bn, s_dn, s_hl};

  int   errors = 0;
  int   checks = 0;
  logic ill_exp = 1'b0;
  logic h_halt = 1'b0;
  cyc_t plan[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control pins per state, straight from the state table.
  function automatic logic [18:0] exp_ctl(int st, logic [5:0] op, logic mr);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa, bn, dn, hl;
    logic [1:0] sb, ao, ps;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa, bn, dn, hl} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mwr = 1; iord = 1; dn = mr; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01;
                bn = (op == 6'b000101); dn = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; dn = 1; end
      11: begin pcw = 1; ps = 2'b10; dn = 1; end
      12: hl = 1;
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rw, rd, sa, sb, ao, ps,
            bn, dn, hl};
  endfunction

  function automatic bit has_jump();
`ifdef MC_JUMP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles per instruction with mem_ready tied high; 0 = illegal.
  function automatic int base_lat(logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100, 6'b000101: return 3;
      6'b001000: return 4;
      6'b000010: return has_jump() ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic rnd1();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(int st, logic mr, logic [5:0] op);
    cyc_t c;
    c.st = st; c.mr = mr; c.op = op;
    plan.push_back(c);
  endtask

  task automatic build(logic [5:0] op, int wf, int wm);
    plan.delete();
    repeat (wf) push(0, 1'b0, op);
    push(0, 1'b1, op);
    push(1, rnd1(), op);
    case (op)
      6'b100011: begin
        push(2, rnd1(), op);
        repeat (wm) push(3, 1'b0, op);
        push(3, 1'b1, op);
        push(4, rnd1(), op);
      end
      6'b101011: begin
        push(2, rnd1(), op);
        repeat (wm) push(5, 1'b0, op);
        push(5, 1'b1, op);
      end
      6'b000000: begin push(6, rnd1(), op); push(7, rnd1(), op); end
      6'b000100, 6'b000101: push(8, rnd1(), op);
      6'b001000: begin push(9, rnd1(), op); push(10, rnd1(), op); end
      6'b000010: if (has_jump()) push(11, rnd1(), op);
      default: ;
    endcase
  endtask

  task automatic step(cyc_t c);
    int hs;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = c.mr;
    opcode = c.op;
    @(negedge clk);
    hs = h_halt ? 12 : c.st;
    check("s_state", 32'(s_st), 32'(c.st));
    check("s_ctl", 32'(s_ctl), 32'(exp_ctl(c.st, c.op, c.mr)));
    check("s_ill", 32'(s_ill), 32'(ill_exp));
    check("h_state", 32'(h_st), 32'(hs));
    check("h_ctl", 32'(h_ctl), 32'(exp_ctl(hs, c.op, c.mr)));
    check("h_ill", 32'(h_ill), 32'(ill_exp));
  endtask

  // Run one instruction; max_steps >= 0 stops it part way.
  task automatic run_instr(logic [5:0] op, int wf, int wm, int max_steps);
    int steps, first_done, dn, irw, lat;
    bit legal, mem_op;
    cyc_t c;
    legal  = base_lat(op) != 0;
    mem_op = (op == 6'b100011) || (op == 6'b101011);
    lat    = base_lat(op) + wf + (mem_op ? wm : 0);
    build(op, wf, wm);
    steps = 0; first_done = 0; dn = 0; irw = 0;
    while (plan.size() > 0 && (max_steps < 0 || steps < max_steps)) begin
      c = plan.pop_front();
      step(c);
      steps++;
      if (s_dn) begin
        dn++;
        if (first_done == 0) first_done = steps;
      end
      if (s_irw) irw++;
    end
    if (max_steps < 0) begin
      check("irw_pulses", 32'(irw), 32'd1);
      check("done_pulses", 32'(dn), legal ? 32'd1 : 32'd0);
      if (legal) check("latency", 32'(first_done), 32'(lat));
      else begin
        ill_exp = 1'b1;
        h_halt  = 1'b1;
      end
    end
  endtask

  task automatic do_reset(int n);
    repeat (n) begin
      @(posedge clk); #1;
      reset = 1'b1;
      mem_ready = rnd1();
      @(negedge clk);
      check("rst_h_ctl", 32'(h_ctl), 32'd0);
      check("rst_s_ctl", 32'(s_ctl), 32'd0);
      check("rst_h_mwr", 32'(h_mwr), 32'd0);
      check("rst_state", 32'({h_st, s_st}), 32'd0);
      check("rst_ill", 32'({h_ill, s_ill}), 32'd0);
    end
    ill_exp = 1'b0;
    h_halt  = 1'b0;
  endtask

  function automatic logic [5:0] rnd_op();
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b000101, 6'b001000, 6'b000010};
    if ($urandom_range(0, 7) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 6)];
  endfunction

  initial begin
    do_reset(3);
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 2, 3, -1);
    run_instr(6'b000101, 0, 0, -1);
    run_instr(6'b000100, 0, 0, -1);
    run_instr(6'b001000, 1, 0, -1);
    run_instr(6'b101011, 0, 2, -1);
    run_instr(6'b000010, 0, 0, -1);
    do_reset(1);
    // Reset lands while a store is waiting in MEM_WRITE.
    run_instr(6'b101011, 0, 5, 4);
    do_reset(3);
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    repeat (5) run_instr(6'b000000, 0, 0, -1);
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      run_instr(rnd_op(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the MIPS datapath. Replaces single-cycle opcode decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the shared-memory, IR, PC, ALU-mux and register-file controls.
- Stalls on a memory ready handshake.
- Supports R-type, LW, SW, BEQ, BNE and ADDI; J is optional.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode parks the FSM in HALT; 0 = skip the instruction and return to FETCH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from the cycle after the IR write
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write qualified by the branch condition
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  latch instruction register
- MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write enable
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- BNE  out  1  invert the zero condition for PCWriteCond
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- illegal_op  out  1  sticky; set on an illegal opcode
- halted  out  1  FSM is in HALT
- state  out  4  current state, for debug

Behaviour:
- Reset is synchronous, active-high. The cycle after reset is sampled high, state=FETCH and illegal_op=0.
- While reset is high, every output is forced to 0. This holds mid-instruction too: a pending MemWrite or RegWrite is dropped, with no partial commit.
- Outputs are Moore decodes of state. Only IRWrite, PCWrite and instr_done are gated by mem_ready, as noted below. Any control not listed for a state is 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stay in FETCH while !mem_ready, else go to DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 or 000101 -> BRANCH
  - 001000 -> ADDI_EXEC
  - 000010 -> JUMP (feature only)
  - any other opcode: set illegal_op, then HALT if HALT_ON_ILLEGAL, else FETCH.
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ (3): MemRead=1, IorD=1. Hold until mem_ready, then MEM_WB.
- MEM_WB (4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next FETCH.
- MEM_WRITE (5): MemWrite=1, IorD=1. Hold until mem_ready. instr_done=mem_ready. Next FETCH.
- R_EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next R_WB.
- R_WB (7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BNE=(opcode==000101), instr_done=1. Next FETCH.
- ADDI_EXEC (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDI_WB.
- ADDI_WB (10): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next FETCH.
- JUMP (11): PCWrite=1, PCSource=10, instr_done=1. Next FETCH.
- HALT (12): halted=1, all other controls 0. Only reset exits HALT.
- Unused encodings 13-15 go to FETCH on the next cycle, with all outputs 0.
- Latency with mem_ready always 1: R=4, LW=5, SW=4, BEQ/BNE=3, ADDI=4, J=3 cycles.
- Each cycle of mem_ready=0 adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- MemRead and MemWrite are never high together. The memory request stays asserted until the cycle mem_ready=1 is sampled.
- illegal_op clears only on reset.

Optional Feature:
- Macro MC_JUMP_EN.
- Defined: opcode 000010 decodes to JUMP (state 11).
- Undefined: 000010 is illegal (sets illegal_op, HALT or skip per parameter), and state 11 is treated as unused.

Decomposition:
- Package mips_ctrl_pkg holds the opcode constants, the 4-bit state encoding, the ALUOp/ALUSrcB/PCSource code constants, and the control-bundle struct typedef.
- Sub-module mc_output_decode: purely combinational state+opcode+mem_ready -> control bundle.
- The FSM register, next-state logic and illegal_op flag stay in multicycle_control.

Test Plan:
- Reset held 3 cycles mid-SW in MEM_WRITE -> MemWrite=0 during reset. state=0, MemRead=1 the cycle after release.
- R-type (opcode 000000), mem_ready=1 -> state sequence 0,1,6,7,0. instr_done only in state 7, with RegDst=1, RegWrite=1.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEM_READ -> 10 cycles total. IRWrite pulses exactly once. MemtoReg=1 in state 4.
- BNE (000101) -> state 8 with PCWriteCond=1, PCSource=01, BNE=1. BEQ (000100) -> same with BNE=0. Each takes 3 cycles.
- Opcode 111111 with HALT_ON_ILLEGAL=1 -> state 12, halted=1 and illegal_op=1, held for 20 cycles. With HALT_ON_ILLEGAL=0 -> back to FETCH, illegal_op=1.
- Opcode 000010: with MC_JUMP_EN -> state 11, PCWrite=1, PCSource=10. Without it -> illegal path.
